// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game controller.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   // Tick counter width; holds any divisor up to 2^25.
   localparam int TICK_W = 25;

   // Direction that would make the snake turn back onto itself.
   function automatic dir_e dir_opposite(input dir_e d);
      dir_e r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         default:   r = DIR_LEFT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings
// (direction inputs, snake model, score display).
interface snake_game_ctrl_if;
   logic        up;
   logic        down;
   logic        left;
   logic        right;
   logic        start;
   logic        enfast;
   logic        collide;
   logic        eat;
   logic        step;
   logic [1:0]  dir;
   logic        clear;
   logic        running;
   logic        game_over;
   logic [15:0] score;

   // Controller side.
   modport slave (
      input  up, down, left, right, start, enfast, collide, eat,
      output step, dir, clear, running, game_over, score
   );

   // Environment side (inputs, model, display).
   modport master (
      output up, down, left, right, start, enfast, collide, eat,
      input  step, dir, clear, running, game_over, score
   );
endinterface

// File: rtl/snake_tick_gen.sv
// Movement tick generator: counts clk cycles while enabled and emits a
// one-cycle step pulse every SLOW_DIV or FAST_DIV cycles.
import snake_pkg::*;

module snake_tick_gen #(
   parameter int SLOW_DIV = 25_000_000,
   parameter int FAST_DIV = 8_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic enfast,
   output logic step,
   output logic fire
);

   localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(SLOW_DIV - 1);
   localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(FAST_DIV - 1);

   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic              step_q, step_d;
   logic [TICK_W-1:0] div_last;

   // Next count; >= (not ==) so a switch to the fast divisor mid-count wraps at once.
   always_comb begin
      fire     = 1'b0;
      cnt_d    = cnt_q;
      div_last = enfast ? FAST_LAST : SLOW_LAST;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q >= div_last) begin
         cnt_d = '0;
         fire  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      step_d = fire;
   end

   // Counter and registered step pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: idle/run/over state, direction arbitration with
// reversal rejection, movement tick and saturating score.
import snake_pkg::*;

module snake_game_ctrl #(
   parameter int SLOW_DIV  = 25_000_000,
   parameter int FAST_DIV  = 8_000_000,
   parameter int SCORE_MAX = 9999
) (
   input  logic             clk,
   input  logic             reset,
   snake_game_ctrl_if.slave bus
);

   localparam logic [15:0] SCORE_TOP = 16'(SCORE_MAX);

   // Bit order {start, right, left, down, up}; low four bits index by dir_e.
   logic [4:0]  btn_q, btn_d;
   logic [4:0]  btn_prev_q, btn_prev_d;
   logic [4:0]  edges;
   logic        has_dir;
   logic        start_edge;
   dir_e        win;

   state_e      state_q, state_d;
   dir_e        dir_q, dir_d;
   dir_e        pend_q, pend_d;
   logic [15:0] score_q, score_d;
   logic        clear_q, clear_d;

   logic        tick_step;
   logic        tick_fire;

   snake_tick_gen #(
      .SLOW_DIV (SLOW_DIV),
      .FAST_DIV (FAST_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (reset),
      .enable (state_q == ST_RUN),
      .enfast (bus.enfast),
      .step   (tick_step),
      .fire   (tick_fire)
   );

   // Rising-edge detection on the registered buttons and priority pick UP > DOWN > LEFT > RIGHT.
   always_comb begin
      btn_d      = {bus.start, bus.right, bus.left, bus.down, bus.up};
      btn_prev_d = btn_q;
      edges      = btn_q & ~btn_prev_q;
      has_dir    = |edges[3:0];
      start_edge = edges[4];
      if (edges[0])      win = DIR_UP;
      else if (edges[1]) win = DIR_DOWN;
      else if (edges[2]) win = DIR_LEFT;
      else               win = DIR_RIGHT;
   end

   // FSM next state and the clear pulse on entering RUN.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (has_dir) begin
               state_d = ST_RUN;
               clear_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.collide) state_d = ST_OVER;
         end
         ST_OVER: begin
            if (start_edge) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending/committed direction and score; reversal is judged against the committed direction.
   always_comb begin
      dir_d   = dir_q;
      pend_d  = pend_q;
      score_d = score_q;
      case (state_q)
         ST_IDLE: begin
            if (has_dir) begin
               score_d = '0;
               dir_d   = DIR_RIGHT;
               pend_d  = (win != dir_opposite(DIR_RIGHT)) ? win : DIR_RIGHT;
            end
         end
         ST_RUN: begin
            if (has_dir && (win != dir_opposite(dir_q))) pend_d = win;
            if (tick_fire) dir_d = pend_q;
            if (!bus.collide && bus.eat && (score_q < SCORE_TOP)) score_d = score_q + 16'd1;
         end
         ST_OVER: begin
            if (start_edge) begin
               dir_d  = DIR_RIGHT;
               pend_d = DIR_RIGHT;
            end
         end
         default: begin
            dir_d  = DIR_RIGHT;
            pend_d = DIR_RIGHT;
         end
      endcase
   end

   // State, direction, score and input history registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q      <= '0;
         btn_prev_q <= '0;
         state_q    <= ST_IDLE;
         dir_q      <= DIR_RIGHT;
         pend_q     <= DIR_RIGHT;
         score_q    <= '0;
         clear_q    <= 1'b0;
      end else begin
         btn_q      <= btn_d;
         btn_prev_q <= btn_prev_d;
         state_q    <= state_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         score_q    <= score_d;
         clear_q    <= clear_d;
      end
   end

   assign bus.step      = tick_step;
   assign bus.dir       = dir_q;
   assign bus.clear     = clear_q;
   assign bus.running   = (state_q == ST_RUN);
   assign bus.game_over = (state_q == ST_OVER);
   assign bus.score     = score_q;

endmodule
